// File: rtl/add32_pipe_pkg.sv
// Shared constants for the two-stage 32-bit add/subtract pipe.
// Saturation constants are used when ADD32_PIPE_SAT_EN is defined.
package add_pkg;

    localparam int          ADD_W    = 32;
    localparam int          ADD_HALF = 16;
    localparam logic [31:0] SAT_POS  = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG  = 32'h8000_0000;

endpackage

// File: rtl/add32_pipe_if.sv
// Operand/result stream bundle for add32_pipe.
// The master drives operands and consumes results; the slave is the adder pipe.
interface add32_pipe_if
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_W
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_x, in_y, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_x, in_y, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

endinterface

// File: rtl/add32_pipe_sixteen_adder.sv
// Purely combinational W-bit ripple slice with carry in and carry out.
// Both pipeline stages of add32_pipe use this slice.
module SixteenAdder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/add32_pipe.sv
// Two-stage pipelined 32-bit add/subtract with valid/ready on both sides.
// Define ADD32_PIPE_SAT_EN for signed saturation of the result in stage 2.
module add32_pipe
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_W,
    parameter int HALF  = ADD_HALF
) (
    input  logic       clk,
    input  logic       rst,
    add32_pipe_if.slave bus
);

    logic [WIDTH-1:0] y_eff_s;
    logic [HALF-1:0]  lo_sum_s;
    logic             c16_s;
    logic [HALF-1:0]  hi_sum_s;
    logic             cout_s;
    logic [WIDTH-1:0] res_sum_s;
    logic             ovf_s;
    logic             zero_s;
    logic             s2_ready_s;
    logic             in_ready_s;
    logic             in_fire_s;

    logic             s1_valid_r;
    logic [HALF-1:0]  s1_lo_r;
    logic             s1_c16_r;
    logic [HALF-1:0]  s1_x_hi_r;
    logic [HALF-1:0]  s1_y_hi_r;
    logic             s1_lo_zero_r;

    logic             out_valid_r;
    logic [WIDTH-1:0] out_sum_r;
    logic             out_cout_r;
    logic             out_ovf_r;
    logic             out_zero_r;

    // Handshake: each stage may load when it is empty or its content leaves this cycle.
    assign s2_ready_s = ~out_valid_r | bus.out_ready;
    assign in_ready_s = ~s1_valid_r | s2_ready_s;
    assign in_fire_s  = bus.in_valid & in_ready_s;

    // Subtraction is X + ~Y + 1; the +1 enters as carry-in of the low slice.
    always_comb begin
        y_eff_s = bus.in_y;
        if (bus.in_sub) begin
            y_eff_s = ~bus.in_y;
        end else begin
            y_eff_s = bus.in_y;
        end
    end

    SixteenAdder #(.W(HALF)) u_lo_add (
        .a    (bus.in_x[HALF-1:0]),
        .b    (y_eff_s[HALF-1:0]),
        .cin  (bus.in_sub),
        .sum  (lo_sum_s),
        .cout (c16_s)
    );

    // Stage 1 register: low-half result, inter-slice carry and the high operand halves.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r   <= 1'b0;
            s1_lo_r      <= {HALF{1'b0}};
            s1_c16_r     <= 1'b0;
            s1_x_hi_r    <= {HALF{1'b0}};
            s1_y_hi_r    <= {HALF{1'b0}};
            s1_lo_zero_r <= 1'b0;
        end else if (in_ready_s) begin
            s1_valid_r <= bus.in_valid;
            if (in_fire_s) begin
                s1_lo_r      <= lo_sum_s;
                s1_c16_r     <= c16_s;
                s1_x_hi_r    <= bus.in_x[WIDTH-1:HALF];
                s1_y_hi_r    <= y_eff_s[WIDTH-1:HALF];
                s1_lo_zero_r <= (lo_sum_s == {HALF{1'b0}});
            end
        end
    end

    SixteenAdder #(.W(HALF)) u_hi_add (
        .a    (s1_x_hi_r),
        .b    (s1_y_hi_r),
        .cin  (s1_c16_r),
        .sum  (hi_sum_s),
        .cout (cout_s)
    );

    // Stage 2 result and flags; the sign bits of x and y' live in the high-half registers.
    always_comb begin
        res_sum_s = {hi_sum_s, s1_lo_r};
        ovf_s     = (s1_x_hi_r[HALF-1] == s1_y_hi_r[HALF-1]) &&
                    (hi_sum_s[HALF-1] != s1_x_hi_r[HALF-1]);
        zero_s    = s1_lo_zero_r && (hi_sum_s == {HALF{1'b0}});
`ifdef ADD32_PIPE_SAT_EN
        if (ovf_s) begin
            if (s1_x_hi_r[HALF-1]) begin
                res_sum_s = SAT_NEG;
            end else begin
                res_sum_s = SAT_POS;
            end
            zero_s = (res_sum_s == {WIDTH{1'b0}});
        end else begin
            zero_s = s1_lo_zero_r && (hi_sum_s == {HALF{1'b0}});
        end
`endif
    end

    // Output register: holds its beat while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_sum_r   <= {WIDTH{1'b0}};
            out_cout_r  <= 1'b0;
            out_ovf_r   <= 1'b0;
            out_zero_r  <= 1'b0;
        end else if (s2_ready_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_sum_r  <= res_sum_s;
                out_cout_r <= cout_s;
                out_ovf_r  <= ovf_s;
                out_zero_r <= zero_s;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = out_sum_r;
    assign bus.out_cout  = out_cout_r;
    assign bus.out_ovf   = out_ovf_r;
    assign bus.out_zero  = out_zero_r;

endmodule

// File: tb/tb_add32_pipe.sv
// Self-checking bench for add32_pipe: directed scenarios plus randomized traffic
// scored against an arithmetic reference model.
module tb_add32_pipe;
    import add_pkg::*;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    add32_pipe_if #(.WIDTH(ADD_W)) bus ();

    add32_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   passes = 0;
    res_t exp_q[$];
    int   issue_q[$];
    int   tick_no = 0;
    int   last_lat = 0;
    res_t last_res;
    int   pop_cnt = 0;
    int   first_pop = -1;
    int   last_pop = -1;
    int   ready_low_cnt = 0;
    int   accepted_cnt = 0;
    bit   prev_stall = 1'b0;
    res_t prev_out;

    logic [31:0] corner [6] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                                32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_FFFF};

    function automatic res_t model(logic [31:0] x, logic [31:0] y, logic sub);
        longint          sx, sy, r;
        longint unsigned ux, uy;
        res_t            e;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = 64'(x);
        uy = 64'(y);
        r  = sub ? (sx - sy) : (sx + sy);
        e.sum  = r[31:0];
        e.ovf  = (r > SMAX) || (r < SMIN);
        e.cout = sub ? (ux >= uy) : ((ux + uy) > 64'h0000_0000_FFFF_FFFF);
`ifdef ADD32_PIPE_SAT_EN
        if (e.ovf) e.sum = (r > 64'sd0) ? SAT_POS : SAT_NEG;
`endif
        e.zero = (e.sum == 32'h0000_0000);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        assert (act === exp) passes = passes + 1;
        else $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic res_t cur_out();
        res_t o;
        o.sum  = bus.out_sum;
        o.cout = bus.out_cout;
        o.ovf  = bus.out_ovf;
        o.zero = bus.out_zero;
        return o;
    endfunction

    // One clock: sample handshakes 1 time unit before the rising edge, then advance.
    task automatic tick();
        res_t o;
        res_t e;
        bit   out_fire;
        bit   in_fire;
        #4;
        o        = cur_out();
        out_fire = bus.out_valid && bus.out_ready;
        in_fire  = bus.in_valid && bus.in_ready;
        if (prev_stall) begin
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_data", 64'(o), 64'(prev_out));
        end
        if (out_fire) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", 64'(o), 64'(e));
                last_res = o;
                last_lat = tick_no - issue_q.pop_front();
                pop_cnt  = pop_cnt + 1;
                if (first_pop < 0) first_pop = tick_no;
                last_pop = tick_no;
            end
        end
        if (in_fire) begin
            exp_q.push_back(model(bus.in_x, bus.in_y, bus.in_sub));
            issue_q.push_back(tick_no);
            accepted_cnt = accepted_cnt + 1;
        end
        if (!bus.in_ready) ready_low_cnt = ready_low_cnt + 1;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out   = o;
        @(posedge clk);
        tick_no = tick_no + 1;
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] x, input logic [31:0] y,
                         input bit s, input bit r);
        bus.in_valid  = v;
        bus.in_x      = x;
        bus.in_y      = y;
        bus.in_sub    = s;
        bus.out_ready = r;
        tick();
    endtask

    task automatic single(input logic [31:0] x, input logic [31:0] y, input bit s);
        drive(1'b1, x, y, s, 1'b1);
        drive(1'b0, $urandom, $urandom, 1'b0, 1'b1);
        drive(1'b0, $urandom, $urandom, 1'b0, 1'b1);
        chk("latency", 64'(last_lat), 64'd2);
        chk("drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_x      = 32'h0;
        bus.in_y      = 32'h0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_outputs", 64'(cur_out()), 64'd0);
        @(negedge clk);

        single(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        chk("t1_sum", 64'(last_res.sum), 64'h0001_0000);
        chk("t1_flags", 64'({last_res.cout, last_res.ovf, last_res.zero}), 64'd0);

        single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
`ifdef ADD32_PIPE_SAT_EN
        chk("t2_sum", 64'(last_res.sum), 64'h7FFF_FFFF);
`else
        chk("t2_sum", 64'(last_res.sum), 64'h8000_0000);
`endif
        chk("t2_ovf", 64'(last_res.ovf), 64'd1);

        single(32'd5, 32'd5, 1'b1);
        chk("t3a_sum", 64'(last_res.sum), 64'd0);
        chk("t3a_zero_cout", 64'({last_res.zero, last_res.cout}), 64'd3);
        single(32'd3, 32'd5, 1'b1);
        chk("t3b_sum", 64'(last_res.sum), 64'hFFFF_FFFE);
        chk("t3b_cout", 64'(last_res.cout), 64'd0);

        // Back-to-back stream
        pop_cnt = 0; first_pop = -1; ready_low_cnt = 0;
        for (int i = 0; i < 8; i++) drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("stream_in_ready", 64'(ready_low_cnt), 64'd0);
        chk("stream_count", 64'(pop_cnt), 64'd8);
        chk("stream_consecutive", 64'(last_pop - first_pop), 64'd7);

        // Backpressure
        accepted_cnt = 0; ready_low_cnt = 0;
        for (int i = 0; i < 4; i++) drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        chk("bp_accepted", 64'(accepted_cnt), 64'd2);
        chk("bp_ready_low", 64'(ready_low_cnt), 64'd2);
        for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset with both stages full
        drive(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        drive(1'b1, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b0);
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        prev_stall = 1'b0;
        exp_q.delete();
        issue_q.delete();
        #1;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        single(32'h8000_0000, 32'h0000_0001, 1'b1);

        // Randomized traffic with operand corners mixed in
        for (int i = 0; i < 400; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
            y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
            drive(1'($urandom_range(0, 3) != 0), x, y, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("random_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
